// File: rtl/wb_spi_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : wb_spi_slave_if
//  Purpose  : Wishbone register port plus SPI pins of the SPI slave peripheral
//  Revision : 1.0  initial release
// ============================================================================
interface wb_spi_slave_if;
   logic [31:0] wb_adr_i;
   logic [31:0] wb_dat_i;
   logic [31:0] wb_dat_o;
   logic        wb_stb_i;
   logic        wb_cyc_i;
   logic        wb_we_i;
   logic [3:0]  wb_sel_i;
   logic        wb_ack_o;
   logic        spi_sck;
   logic        spi_mosi;
   logic        spi_ss_n;
   logic        spi_miso;
   logic        intr;

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
      output wb_dat_o, wb_ack_o,
      input  spi_sck, spi_mosi, spi_ss_n,
      output spi_miso, intr
   );

   modport master (
      output wb_adr_i, wb_dat_i, wb_stb_i, wb_cyc_i, wb_we_i, wb_sel_i,
      input  wb_dat_o, wb_ack_o,
      output spi_sck, spi_mosi, spi_ss_n,
      input  spi_miso, intr
   );
endinterface
`default_nettype wire

// File: rtl/wb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : wb_spi_slave
//  Purpose  : SPI mode-0 slave with RX FIFO and TX holding register on Wishbone
//  Revision : 1.0  initial release
// ============================================================================
module wb_spi_slave #(
   parameter int RX_DEPTH = 4
) (
   input  wire logic     clk,
   input  wire logic     reset,
   wb_spi_slave_if.slave bus
);
   localparam int              c_PTR_W = $clog2(RX_DEPTH);
   localparam logic [c_PTR_W:0] c_FULL  = RX_DEPTH[c_PTR_W:0];

   // synchronizers and edge detection
   logic [1:0] r_sck_s, r_mosi_s, r_ss_s;
   logic       r_sck_d, r_ss_d, r_armed;

   // SPI shifter
   logic [2:0] r_bitcnt;
   logic [7:0] r_rx_shift, r_tx_shift;
   logic       r_byte_done;

   // RX FIFO
   logic [7:0]         r_mem [RX_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr, r_rd_ptr;
   logic [c_PTR_W:0]   r_count;

   // register file
   logic        r_ack, r_intr, r_tx_full, r_ovr, r_udr;
   logic [31:0] r_dat_o;
   logic [7:0]  r_hold;
   logic [2:0]  r_ctrl;

   logic        w_sel, w_rise, w_fall, w_ss_fall, w_byte_start, w_push, w_push_ok;
   logic        w_full, w_avail, w_req, w_wr, w_rd, w_pop;
   logic [1:0]  w_reg;
   logic [7:0]  w_rx_byte;
   logic [31:0] w_status, w_rd_data;
   logic        w_unused;

   // r_armed blocks a transfer until ss_n has been seen high after reset
   assign w_sel        = r_armed & ~r_ss_s[1];
   assign w_rise       = w_sel & r_sck_s[1] & ~r_sck_d;
   assign w_fall       = w_sel & ~r_sck_s[1] & r_sck_d;
   assign w_ss_fall    = r_armed & r_ss_d & ~r_ss_s[1];
   assign w_byte_start = w_ss_fall | (w_fall & r_byte_done);
   assign w_rx_byte    = {r_rx_shift[6:0], r_mosi_s[1]};
   assign w_push       = w_rise & (r_bitcnt == 3'd7);
   assign w_full       = (r_count == c_FULL);
   assign w_avail      = (r_count != '0);
   assign w_push_ok    = w_push & ~w_full;

   assign w_req = bus.wb_stb_i & bus.wb_cyc_i & ~r_ack;
   assign w_wr  = w_req & bus.wb_we_i;
   assign w_rd  = w_req & ~bus.wb_we_i;
   assign w_reg = bus.wb_adr_i[3:2];
   assign w_pop = w_rd & (w_reg == 2'd0) & w_avail;

   assign w_status = {27'b0, r_udr, r_ovr, ~r_tx_full, w_full, w_avail};

   assign bus.wb_ack_o = r_ack;
   assign bus.wb_dat_o = r_dat_o;
   assign bus.intr     = r_intr;
   assign bus.spi_miso = w_sel ? r_tx_shift[7] : 1'b1;

   assign w_unused = ^{bus.wb_sel_i, bus.wb_adr_i[31:4], bus.wb_adr_i[1:0], bus.wb_dat_i[31:8]};

   always_comb begin
      w_rd_data = '0;
      case (w_reg)
         2'd0:    if (w_avail) w_rd_data = {24'b0, r_mem[r_rd_ptr]};
         2'd1:    w_rd_data = {24'b0, r_hold};
         2'd2:    w_rd_data = w_status;
         default: w_rd_data = {29'b0, r_ctrl};
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sck_s  <= 2'b00;
         r_mosi_s <= 2'b00;
         r_ss_s   <= 2'b11;
         r_sck_d  <= 1'b0;
         r_ss_d   <= 1'b1;
         r_armed  <= 1'b0;
      end else begin
         r_sck_s  <= {r_sck_s[0], bus.spi_sck};
         r_mosi_s <= {r_mosi_s[0], bus.spi_mosi};
         r_ss_s   <= {r_ss_s[0], bus.spi_ss_n};
         r_sck_d  <= r_sck_s[1];
         r_ss_d   <= r_ss_s[1];
         if (r_ss_s[1]) r_armed <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bitcnt    <= 3'd0;
         r_rx_shift  <= 8'h00;
         r_tx_shift  <= 8'hFF;
         r_byte_done <= 1'b0;
      end else if (!w_sel) begin
         r_bitcnt    <= 3'd0;
         r_rx_shift  <= 8'h00;
         r_byte_done <= 1'b0;
      end else begin
         // the next byte is loaded on the sck fall that ends the previous one
         if (w_byte_start) begin
            r_tx_shift  <= r_tx_full ? r_hold : 8'hFF;
            r_byte_done <= 1'b0;
         end else if (w_fall) begin
            r_tx_shift <= {r_tx_shift[6:0], 1'b0};
         end
         if (w_rise) begin
            r_rx_shift <= w_rx_byte;
            r_bitcnt   <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7) r_byte_done <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < RX_DEPTH; i++) r_mem[i] <= 8'h00;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_rx_byte;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ack     <= 1'b0;
         r_dat_o   <= '0;
         r_hold    <= 8'h00;
         r_tx_full <= 1'b0;
         r_ctrl    <= 3'b000;
         r_ovr     <= 1'b0;
         r_udr     <= 1'b0;
         r_intr    <= 1'b0;
      end else begin
         r_ack   <= w_req;
         r_dat_o <= w_rd ? w_rd_data : 32'h0;
         if (w_wr && w_reg == 2'd2) begin
            if (bus.wb_dat_i[3]) r_ovr <= 1'b0;
            if (bus.wb_dat_i[4]) r_udr <= 1'b0;
         end
         if (w_wr && w_reg == 2'd3) r_ctrl <= bus.wb_dat_i[2:0];
         // a TXDATA write in the load cycle must survive the load
         if (w_byte_start) begin
            if (r_tx_full) r_tx_full <= 1'b0;
            else           r_udr     <= 1'b1;
         end
         if (w_wr && w_reg == 2'd1) begin
            r_hold    <= bus.wb_dat_i[7:0];
            r_tx_full <= 1'b1;
         end
         if (w_push && w_full) r_ovr <= 1'b1;
         r_intr <= |(r_ctrl & {r_ovr, ~r_tx_full, w_avail});
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_wb_spi_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_spi_slave
//  Purpose  : Self-checking bench for wb_spi_slave (vectors, corners, random)
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_spi_slave;
   localparam int RX_DEPTH = 4;
   localparam int H        = 8;

   typedef struct packed {
      logic [1:0]  r;
      logic        we;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   typedef logic [7:0] bytes_t [8];

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   wb_spi_slave_if bus();
   wb_spi_slave #(.RX_DEPTH(RX_DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   // reference model state
   logic [7:0] m_rx [$];
   logic       m_ovr, m_udr, m_tx_full;
   logic [7:0] m_hold;
   logic [2:0] m_ctrl;

   function automatic void m_reset();
      m_rx.delete();
      m_ovr = 0; m_udr = 0; m_tx_full = 0; m_hold = 8'h00; m_ctrl = 3'b000;
   endfunction

   function automatic logic [31:0] m_status();
      return {27'b0, m_udr, m_ovr, ~m_tx_full, m_rx.size() == RX_DEPTH, m_rx.size() != 0};
   endfunction

   function automatic logic m_intr();
      return |(m_ctrl & {m_ovr, ~m_tx_full, m_rx.size() != 0});
   endfunction

   function automatic logic [7:0] m_start();
      if (m_tx_full) begin
         m_tx_full = 0;
         return m_hold;
      end
      m_udr = 1;
      return 8'hFF;
   endfunction

   function automatic void m_push(input logic [7:0] b);
      if (m_rx.size() < RX_DEPTH) m_rx.push_back(b);
      else m_ovr = 1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wb(input logic [1:0] r, input logic we, input logic [31:0] d, output logic [31:0] q);
      int n;
      @(posedge clk); #1;
      bus.wb_adr_i = {28'h0, r, 2'b00};
      bus.wb_we_i  = we;
      bus.wb_dat_i = d;
      bus.wb_stb_i = 1'b1;
      bus.wb_cyc_i = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!bus.wb_ack_o && n < 8);
      chk("wb_ack", {31'b0, bus.wb_ack_o}, 32'h1);
      q = bus.wb_dat_o;
      bus.wb_stb_i = 1'b0;
      bus.wb_cyc_i = 1'b0;
      bus.wb_we_i  = 1'b0;
   endtask

   task automatic op_rd(input logic [1:0] r, input string nm, output logic [31:0] q);
      logic [31:0] e;
      wb(r, 1'b0, 32'h0, q);
      case (r)
         2'd0:    e = (m_rx.size() != 0) ? {24'h0, m_rx.pop_front()} : 32'h0;
         2'd1:    e = {24'h0, m_hold};
         2'd2:    e = m_status();
         default: e = {29'h0, m_ctrl};
      endcase
      chk(nm, q, e);
   endtask

   task automatic op_wr(input logic [1:0] r, input logic [31:0] d);
      logic [31:0] q;
      wb(r, 1'b1, d, q);
      case (r)
         2'd1: begin m_hold = d[7:0]; m_tx_full = 1; end
         2'd2: begin if (d[3]) m_ovr = 0; if (d[4]) m_udr = 0; end
         2'd3: m_ctrl = d[2:0];
         default: ;
      endcase
   endtask

   task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] m);
      m = 8'h00;
      for (int i = 0; i < n; i++) begin
         bus.spi_mosi = b[7-i];
         repeat (H) @(posedge clk); #1;
         m = {m[6:0], bus.spi_miso};
         bus.spi_sck = 1'b1;
         repeat (H) @(posedge clk); #1;
         bus.spi_sck = 1'b0;
      end
   endtask

   task automatic ss_low();
      bus.spi_ss_n = 1'b0;
      repeat (8) @(posedge clk); #1;
   endtask

   task automatic ss_high();
      repeat (4) @(posedge clk); #1;
      bus.spi_ss_n = 1'b1;
      repeat (6) @(posedge clk); #1;
   endtask

   task automatic xfer(input bytes_t data, input int n);
      logic [7:0] ld, m;
      ss_low();
      ld = m_start();
      for (int k = 0; k < n; k++) begin
         spi_bits(data[k], 8, m);
         chk("miso_byte", {24'h0, m}, {24'h0, ld});
         m_push(data[k]);
         ld = m_start();
      end
      ss_high();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t        v [15];
      bytes_t      bt;
      logic [31:0] q;
      logic [7:0]  m;
      int          n;

      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
      bus.wb_we_i = 0; bus.wb_sel_i = 4'hF;
      bus.spi_sck = 0; bus.spi_mosi = 0; bus.spi_ss_n = 1;
      m_reset();

      repeat (3) @(posedge clk); #1;
      chk("rst_ack",  {31'b0, bus.wb_ack_o}, 32'h0);
      chk("rst_dat",  bus.wb_dat_o, 32'h0);
      chk("rst_miso", {31'b0, bus.spi_miso}, 32'h1);
      chk("rst_intr", {31'b0, bus.intr}, 32'h0);
      reset = 1'b0;
      repeat (4) @(posedge clk); #1;

      // register-level vectors from reset
      v[0]  = '{2'd2, 1'b0, 32'h0,         32'h4};
      v[1]  = '{2'd3, 1'b0, 32'h0,         32'h0};
      v[2]  = '{2'd0, 1'b0, 32'h0,         32'h0};
      v[3]  = '{2'd1, 1'b0, 32'h0,         32'h0};
      v[4]  = '{2'd3, 1'b1, 32'hFFFF_FFFD, 32'h0};
      v[5]  = '{2'd3, 1'b0, 32'h0,         32'h5};
      v[6]  = '{2'd1, 1'b1, 32'h1234_56C3, 32'h0};
      v[7]  = '{2'd1, 1'b0, 32'h0,         32'hC3};
      v[8]  = '{2'd2, 1'b0, 32'h0,         32'h0};
      v[9]  = '{2'd2, 1'b1, 32'hFFFF_FFFF, 32'h0};
      v[10] = '{2'd2, 1'b0, 32'h0,         32'h0};
      v[11] = '{2'd3, 1'b1, 32'h0,         32'h0};
      v[12] = '{2'd3, 1'b0, 32'h0,         32'h0};
      v[13] = '{2'd0, 1'b1, 32'h55,        32'h0};
      v[14] = '{2'd0, 1'b0, 32'h0,         32'h0};
      for (int i = 0; i < 15; i++) begin
         if (v[i].we) op_wr(v[i].r, v[i].d);
         else begin
            wb(v[i].r, 1'b0, 32'h0, q);
            chk($sformatf("vec%0d", i), q, v[i].exp);
         end
      end

      // preloaded TX byte, single received byte
      op_wr(2'd1, 32'h3C);
      bt[0] = 8'hA5;
      xfer(bt, 1);
      op_rd(2'd0, "t1_rx", q);
      chk("t1_rx_const", q, 32'hA5);
      op_rd(2'd2, "t1_status", q);
      chk("t1_avail", {31'b0, q[0]}, 32'h0);

      // overrun: five bytes into a four-entry FIFO
      for (int k = 0; k < 5; k++) bt[k] = 8'(k + 1);
      xfer(bt, 5);
      for (int k = 1; k <= 4; k++) begin
         op_rd(2'd0, "t2_rx", q);
         chk("t2_rx_const", q, 32'(k));
      end
      op_rd(2'd0, "t2_rx_empty", q);
      op_wr(2'd2, 32'h10);
      op_rd(2'd2, "t2_status", q);
      chk("t2_status_const", q, 32'h0C);
      op_wr(2'd2, 32'h08);

      // underrun with empty holding register
      bt[0] = 8'h5E;
      xfer(bt, 1);
      op_rd(2'd2, "t3_status", q);
      chk("t3_udr", {31'b0, q[4]}, 32'h1);
      op_wr(2'd2, 32'h10);
      op_rd(2'd2, "t3_status_clr", q);
      op_rd(2'd0, "t3_rx", q);

      // ss_n released after five bits
      ss_low();
      void'(m_start());
      spi_bits(8'hF0, 5, m);
      ss_high();
      op_rd(2'd2, "t4_status", q);
      chk("t4_empty", {31'b0, q[0]}, 32'h0);
      bt[0] = 8'h81;
      xfer(bt, 1);
      op_rd(2'd0, "t4_rx", q);
      chk("t4_rx_const", q, 32'h81);

      // rx_avail interrupt latency and clear
      op_wr(2'd2, 32'h18);
      op_wr(2'd3, 32'h1);
      ss_low();
      void'(m_start());
      spi_bits(8'h42, 7, m);
      bus.spi_mosi = 1'b0;
      repeat (H) @(posedge clk); #1;
      bus.spi_sck = 1'b1;
      n = 0;
      while (!bus.intr && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      chk("t5_intr", {31'b0, bus.intr}, 32'h1);
      chk("t5_intr_latency_le4", {31'b0, n <= 4}, 32'h1);
      repeat (H) @(posedge clk); #1;
      bus.spi_sck = 1'b0;
      m_push(8'h42);
      void'(m_start());
      ss_high();
      op_rd(2'd0, "t5_rx", q);
      @(posedge clk); #1;
      chk("t5_intr_clr", {31'b0, bus.intr}, 32'h0);
      op_wr(2'd3, 32'h0);

      // asynchronous reset in the middle of a byte
      op_wr(2'd1, 32'h00);
      ss_low();
      void'(m_start());
      spi_bits(8'h33, 3, m);
      chk("t6_miso_pre", {31'b0, bus.spi_miso}, 32'h0);
      #2 reset = 1'b1;
      #1;
      chk("t6_ack",  {31'b0, bus.wb_ack_o}, 32'h0);
      chk("t6_miso", {31'b0, bus.spi_miso}, 32'h1);
      @(posedge clk); #1;
      reset = 1'b0;
      m_reset();
      op_rd(2'd2, "t6_status", q);
      chk("t6_status_const", q, 32'h04);
      chk("t6_miso_unarmed", {31'b0, bus.spi_miso}, 32'h1);
      ss_high();
      bt[0] = 8'h6D;
      xfer(bt, 1);
      op_rd(2'd0, "t6_rx_after", q);

      // randomized operations against the model
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 6))
            0: op_wr(2'd1, $urandom);
            1: op_rd(2'd0, "rnd_rx", q);
            2: op_rd(2'd2, "rnd_status", q);
            3: op_wr(2'd2, $urandom);
            4: op_wr(2'd3, $urandom);
            5: begin
               op_rd(2'd1, "rnd_tx", q);
               op_rd(2'd3, "rnd_ctrl", q);
            end
            default: begin
               n = $urandom_range(1, 3);
               for (int k = 0; k < 8; k++) bt[k] = 8'($urandom);
               xfer(bt, n);
            end
         endcase
         repeat (2) @(posedge clk); #1;
         chk("rnd_intr", {31'b0, bus.intr}, {31'b0, m_intr()});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
